// File: rtl/branch_predictor_unit.sv
// branch_predictor_unit: tagged BTB with saturating counters, circular RAS and mispredict counter
module branch_predictor_unit #(
  parameter int ADDR_W    = 32,
  parameter int ENTRIES   = 16,
  parameter int CTR_BITS  = 2,
  parameter int RAS_DEPTH = 4,
  parameter int PERF_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc_if,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_taken,
  input  logic              upd_pred_taken,
  input  logic              ras_push,
  input  logic [ADDR_W-1:0] ras_push_addr,
  input  logic              ras_pop,
  output logic [ADDR_W-1:0] ras_top,
  output logic              ras_valid,
  output logic [PERF_W-1:0] perf_mispredict
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;
  localparam int RP_W  = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
  localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(1) << (CTR_BITS - 1);
  localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_WT - CTR_BITS'(1);
  localparam logic [CNT_W-1:0]    CNT_MAX = CNT_W'(RAS_DEPTH);

  logic [ENTRIES-1:0]  valid_q;
  logic [TAG_W-1:0]    tag_q    [ENTRIES];
  logic [ADDR_W-1:0]   target_q [ENTRIES];
  logic [CTR_BITS-1:0] ctr_q    [ENTRIES];
  logic [ADDR_W-1:0]   ras_q    [RAS_DEPTH];
  logic [RP_W-1:0]     tp_q, tp_m1;
  logic [CNT_W-1:0]    cnt_q;
  logic [IDX_W-1:0]    lk_idx, up_idx;
  logic [TAG_W-1:0]    lk_tag, up_tag;
  logic                up_hit;

  assign lk_idx = pc_if[IDX_W+1:2];
  assign lk_tag = pc_if[ADDR_W-1:IDX_W+2];
  assign up_idx = upd_pc[IDX_W+1:2];
  assign up_tag = upd_pc[ADDR_W-1:IDX_W+2];
  assign tp_m1  = tp_q - RP_W'(1);

  // combinational lookup and RAS top; no bypass of same-cycle updates
  always_comb begin
    pred_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    pred_taken  = pred_hit && ctr_q[lk_idx][CTR_BITS-1];
    pred_target = pred_hit ? target_q[lk_idx] : pc_if + ADDR_W'(4);
    up_hit      = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    ras_valid   = cnt_q != '0;
    ras_top     = ras_valid ? ras_q[tp_m1] : '0;
  end

  // BTB training: hits adjust counter/target, taken misses allocate weakly-taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_WNT;
      end
    end else if (upd_valid) begin
      if (up_hit) begin
        if (upd_taken) target_q[up_idx] <= upd_target;
        ctr_q[up_idx] <= upd_taken ? (ctr_q[up_idx] == CTR_MAX ? CTR_MAX : ctr_q[up_idx] + CTR_BITS'(1))
                                   : (ctr_q[up_idx] == '0 ? '0 : ctr_q[up_idx] - CTR_BITS'(1));
      end else if (upd_taken) begin
        valid_q[up_idx]  <= 1'b1;
        tag_q[up_idx]    <= up_tag;
        target_q[up_idx] <= upd_target;
        ctr_q[up_idx]    <= CTR_WT;
      end
    end
  end

  // saturating count of resolved branches whose outcome differed from the prediction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perf_mispredict <= '0;
    else if (upd_valid && (upd_taken != upd_pred_taken) && perf_mispredict != '1)
      perf_mispredict <= perf_mispredict + PERF_W'(1);
  end

  // circular RAS; push+pop on a non-empty stack replaces the top in place
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tp_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
    end else if (ras_push && ras_pop && ras_valid) begin
      ras_q[tp_m1] <= ras_push_addr;
    end else if (ras_push) begin
      ras_q[tp_q] <= ras_push_addr;
      tp_q        <= tp_q + RP_W'(1);
      cnt_q       <= cnt_q == CNT_MAX ? CNT_MAX : cnt_q + CNT_W'(1);
    end else if (ras_pop && ras_valid) begin
      tp_q  <= tp_m1;
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_branch_predictor_unit.sv
// tb_branch_predictor_unit: directed self-checking bench for branch_predictor_unit
module tb_branch_predictor_unit;
  logic        clk = 0, rst_n = 0;
  logic [31:0] pc_if = 0, upd_pc = 0, upd_target = 0, ras_push_addr = 0;
  logic        upd_valid = 0, upd_taken = 0, upd_pred_taken = 0, ras_push = 0, ras_pop = 0;
  logic        pred_hit, pred_taken, ras_valid;
  logic [31:0] pred_target, ras_top;
  logic [15:0] perf_mispredict;
  int          checks = 0, errors = 0;

  branch_predictor_unit dut (
    .clk(clk), .rst_n(rst_n), .pc_if(pc_if), .pred_hit(pred_hit), .pred_taken(pred_taken),
    .pred_target(pred_target), .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target),
    .upd_taken(upd_taken), .upd_pred_taken(upd_pred_taken), .ras_push(ras_push),
    .ras_push_addr(ras_push_addr), .ras_pop(ras_pop), .ras_top(ras_top), .ras_valid(ras_valid),
    .perf_mispredict(perf_mispredict)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic t, input logic p);
    upd_valid = 1; upd_pc = pc; upd_target = tgt; upd_taken = t; upd_pred_taken = p;
    step();
    upd_valid = 0;
  endtask

  task automatic ras_op(input logic push, input logic pop, input logic [31:0] a);
    ras_push = push; ras_pop = pop; ras_push_addr = a;
    step();
    ras_push = 0; ras_pop = 0;
  endtask

  task automatic lookup_chk(input string nm, input logic [31:0] pc, input logic eh, input logic et, input logic [31:0] etg);
    pc_if = pc;
    #1;
    checks++; if (pred_hit !== eh) begin errors++; $display("FAIL %s hit: got %0b want %0b", nm, pred_hit, eh); end
    checks++; if (pred_taken !== et) begin errors++; $display("FAIL %s taken: got %0b want %0b", nm, pred_taken, et); end
    checks++; if (pred_target !== etg) begin errors++; $display("FAIL %s target: got %h want %h", nm, pred_target, etg); end
  endtask

  task automatic test_reset();
    rst_n = 0; pc_if = 32'h40;
    #2;
    lookup_chk("reset", 32'h40, 0, 0, 32'h44);
    checks++; if (ras_valid !== 1'b0) begin errors++; $display("FAIL reset ras_valid: got %0b want 0", ras_valid); end
    checks++; if (ras_top !== 32'h0) begin errors++; $display("FAIL reset ras_top: got %h want 0", ras_top); end
    checks++; if (perf_mispredict !== 16'd0) begin errors++; $display("FAIL reset perf: got %0d want 0", perf_mispredict); end
    step();
    #2 rst_n = 1;
    step();
  endtask

  task automatic test_alloc();
    upd_valid = 1; upd_pc = 32'h40; upd_target = 32'h80; upd_taken = 1; upd_pred_taken = 0;
    lookup_chk("no_bypass", 32'h40, 0, 0, 32'h44);
    step();
    upd_valid = 0;
    lookup_chk("alloc", 32'h40, 1, 1, 32'h80);
    checks++; if (perf_mispredict !== 16'd1) begin errors++; $display("FAIL alloc perf: got %0d want 1", perf_mispredict); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 4; i++) upd(32'h40, 32'h80, 1, 1);
    lookup_chk("sat_up", 32'h40, 1, 1, 32'h80);
    checks++; if (perf_mispredict !== 16'd1) begin errors++; $display("FAIL sat perf1: got %0d want 1", perf_mispredict); end
    upd(32'h40, 32'h999, 0, 1);
    lookup_chk("sat_nt1", 32'h40, 1, 1, 32'h80);
    upd(32'h40, 32'h999, 0, 1);
    lookup_chk("sat_nt2", 32'h40, 1, 0, 32'h80);
    checks++; if (perf_mispredict !== 16'd3) begin errors++; $display("FAIL sat perf3: got %0d want 3", perf_mispredict); end
    upd(32'h40, 32'h80, 0, 0);
    upd(32'h40, 32'h80, 0, 0);
    upd(32'h40, 32'h84, 1, 0);
    lookup_chk("sat_floor", 32'h40, 1, 0, 32'h84);
    checks++; if (perf_mispredict !== 16'd4) begin errors++; $display("FAIL sat perf4: got %0d want 4", perf_mispredict); end
    upd(32'hC0, 32'h500, 0, 0);
    lookup_chk("miss_nt_keep", 32'h40, 1, 0, 32'h84);
    lookup_chk("other_idx", 32'h44, 0, 0, 32'h48);
  endtask

  task automatic test_alias();
    upd(32'h80, 32'h200, 1, 1);
    lookup_chk("alias_old", 32'h40, 0, 0, 32'h44);
    lookup_chk("alias_new", 32'h80, 1, 1, 32'h200);
    checks++; if (perf_mispredict !== 16'd4) begin errors++; $display("FAIL alias perf: got %0d want 4", perf_mispredict); end
  endtask

  task automatic test_ras();
    logic [31:0] exp_pop [3] = '{32'h40, 32'h30, 32'h20};
    ras_op(1, 0, 32'h10);
    checks++; if (ras_top !== 32'h10 || ras_valid !== 1'b1) begin errors++; $display("FAIL ras_first: got %h/%0b want 10/1", ras_top, ras_valid); end
    for (int i = 2; i <= 5; i++) ras_op(1, 0, 32'(i * 16));
    checks++; if (ras_top !== 32'h50) begin errors++; $display("FAIL ras_full_top: got %h want 50", ras_top); end
    for (int i = 0; i < 3; i++) begin
      ras_op(0, 1, 0);
      checks++; if (ras_top !== exp_pop[i] || ras_valid !== 1'b1) begin errors++; $display("FAIL ras_pop%0d: got %h/%0b want %h/1", i, ras_top, ras_valid, exp_pop[i]); end
    end
    ras_op(0, 1, 0);
    checks++; if (ras_valid !== 1'b0 || ras_top !== 32'h0) begin errors++; $display("FAIL ras_empty: got %h/%0b want 0/0", ras_top, ras_valid); end
    ras_op(0, 1, 0);
    checks++; if (ras_valid !== 1'b0) begin errors++; $display("FAIL ras_underflow: got %0b want 0", ras_valid); end
    ras_op(1, 1, 32'hA0);
    checks++; if (ras_top !== 32'hA0 || ras_valid !== 1'b1) begin errors++; $display("FAIL ras_pushpop_empty: got %h/%0b want a0/1", ras_top, ras_valid); end
    ras_op(1, 0, 32'hB0);
    ras_op(1, 1, 32'hC0);
    checks++; if (ras_top !== 32'hC0) begin errors++; $display("FAIL ras_replace: got %h want c0", ras_top); end
    ras_op(0, 1, 0);
    checks++; if (ras_top !== 32'hA0 || ras_valid !== 1'b1) begin errors++; $display("FAIL ras_after_replace: got %h/%0b want a0/1", ras_top, ras_valid); end
    ras_op(0, 1, 0);
    checks++; if (ras_valid !== 1'b0) begin errors++; $display("FAIL ras_drain: got %0b want 0", ras_valid); end
  endtask

  task automatic test_mid_reset();
    ras_op(1, 0, 32'h77);
    #2 rst_n = 0;
    #1;
    lookup_chk("mid_rst", 32'h80, 0, 0, 32'h84);
    checks++; if (ras_valid !== 1'b0 || ras_top !== 32'h0) begin errors++; $display("FAIL mid_rst ras: got %h/%0b want 0/0", ras_top, ras_valid); end
    checks++; if (perf_mispredict !== 16'd0) begin errors++; $display("FAIL mid_rst perf: got %0d want 0", perf_mispredict); end
    step();
    #2 rst_n = 1;
    step();
    upd(32'h100, 32'h300, 1, 0);
    lookup_chk("post_rst", 32'h100, 1, 1, 32'h300);
    checks++; if (perf_mispredict !== 16'd1) begin errors++; $display("FAIL post_rst perf: got %0d want 1", perf_mispredict); end
  endtask

  initial begin
    test_reset();
    test_alloc();
    test_saturation();
    test_alias();
    test_ras();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
